// File: rtl/seg7_frame_capture.sv
// Receive side of the 4-digit multiplexed 7-segment bus: debounces each anode/cathode
// pair, decodes it back to BCD and reassembles complete 16-bit frames.
module seg7_frame_capture #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1600000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  anode,
  input  logic [7:0]  cathode,
  output logic [15:0] value,
  output logic        value_valid,
  output logic        value_changed,
  output logic        seg_err,
  output logic        stale
);

  localparam logic [7:0]  STAB_MAX = 8'(STABLE_CYCLES);
  localparam logic [20:0] TO_MAX   = 21'(TIMEOUT_CYCLES);

  logic [3:0]  anode_q, anode_p;
  logic [7:0]  cathode_q, cathode_p;
  logic [7:0]  stab_cnt, stab_next;
  logic        legal, same, hit;
  logic [1:0]  digit_sel;
  logic [3:0]  decoded;
  logic        acc;
  logic [1:0]  acc_digit;
  logic [3:0]  acc_code;
  logic [15:0] shadow;
  logic [3:0]  seen, seen_next;
  logic        first;
  logic [20:0] to_cnt;
  logic        complete, expire;

  always_comb begin
    legal     = 1'b1;
    digit_sel = 2'd0;
    case (anode_q)
      4'b1110: digit_sel = 2'd0;
      4'b1101: digit_sel = 2'd1;
      4'b1011: digit_sel = 2'd2;
      4'b0111: digit_sel = 2'd3;
      default: legal = 1'b0;
    endcase

    same = (anode_q == anode_p) && (cathode_q == cathode_p);
    if (same && legal)
      stab_next = (stab_cnt == STAB_MAX) ? stab_cnt : stab_cnt + 8'd1;
    else
      stab_next = 8'd1;
    // Fire only on the transition into the terminal count, never while saturated.
    hit = legal && (stab_next == STAB_MAX) && !(same && (stab_cnt == STAB_MAX));

    case (cathode_q[6:0])
      7'b1000000: decoded = 4'h0;
      7'b1111001: decoded = 4'h1;
      7'b0100100: decoded = 4'h2;
      7'b0110000: decoded = 4'h3;
      7'b0011001: decoded = 4'h4;
      7'b0010010: decoded = 4'h5;
      7'b0000010: decoded = 4'h6;
      7'b1111000: decoded = 4'h7;
      7'b0000000: decoded = 4'h8;
      7'b0010000: decoded = 4'h9;
      7'b1111111: decoded = 4'hF;
      default:    decoded = 4'hE;
    endcase

    complete = (seen == 4'hF);
    expire   = !acc && (to_cnt != TO_MAX) && ((to_cnt + 21'd1) == TO_MAX);

    seen_next = (complete || expire) ? 4'h0 : seen;
    if (acc)
      seen_next[acc_digit] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      anode_q       <= 4'hF;
      anode_p       <= 4'hF;
      cathode_q     <= 8'hFF;
      cathode_p     <= 8'hFF;
      stab_cnt      <= 8'd0;
      acc           <= 1'b0;
      acc_digit     <= 2'd0;
      acc_code      <= 4'h0;
      shadow        <= 16'h0000;
      seen          <= 4'h0;
      first         <= 1'b1;
      to_cnt        <= 21'd0;
      value         <= 16'h0000;
      value_valid   <= 1'b0;
      value_changed <= 1'b0;
      seg_err       <= 1'b0;
      stale         <= 1'b1;
    end else begin
      anode_q   <= anode;
      cathode_q <= cathode;
      anode_p   <= anode_q;
      cathode_p <= cathode_q;
      stab_cnt  <= stab_next;

      acc       <= hit;
      acc_digit <= digit_sel;
      acc_code  <= decoded;

      if (acc) begin
        shadow[{acc_digit, 2'b00} +: 4] <= acc_code;
        if (acc_code == 4'hE)
          seg_err <= 1'b1;
      end
      seen <= seen_next;

      if (acc)
        to_cnt <= 21'd0;
      else if (to_cnt != TO_MAX)
        to_cnt <= to_cnt + 21'd1;

      value_valid   <= complete;
      value_changed <= complete && ((shadow != value) || first);
      if (complete) begin
        value <= shadow;
        first <= 1'b0;
      end

      if (expire)
        stale <= 1'b1;
      else if (complete)
        stale <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg7_frame_capture.sv
// Directed bench for seg7_frame_capture with a short timeout so stale behaviour is reachable.
module tb_seg7_frame_capture;

  logic        clk;
  logic        rst;
  logic [3:0]  anode;
  logic [7:0]  cathode;
  logic [15:0] value;
  logic        value_valid, value_changed, seg_err, stale;

  int n_cmp = 0;
  int n_bad = 0;
  int vcnt  = 0;
  int ccnt  = 0;
  int v0, c0;

  logic [7:0] seg [0:9];

  seg7_frame_capture #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst), .anode(anode), .cathode(cathode),
    .value(value), .value_valid(value_valid), .value_changed(value_changed),
    .seg_err(seg_err), .stale(stale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (value_valid) vcnt++;
    if (value_changed) ccnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic [3:0] a, input logic [7:0] c, input int n);
    anode   = a;
    cathode = c;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input logic [7:0] c3, input logic [7:0] c2,
                      input logic [7:0] c1, input logic [7:0] c0);
    hold(4'b1110, c0, 6);
    hold(4'b1101, c1, 6);
    hold(4'b1011, c2, 6);
    hold(4'b0111, c3, 6);
    hold(4'b1111, 8'hFF, 4);
  endtask

  initial begin
    seg[0] = 8'hC0; seg[1] = 8'hF9; seg[2] = 8'hA4; seg[3] = 8'hB0; seg[4] = 8'h99;
    seg[5] = 8'h92; seg[6] = 8'h82; seg[7] = 8'hF8; seg[8] = 8'h80; seg[9] = 8'h90;

    rst = 1'b0; anode = 4'hF; cathode = 8'hFF;
    repeat (3) @(negedge clk);
    chk("rst_value", value, 16'h0000);
    chk("rst_valid", value_valid, 1'b0);
    chk("rst_changed", value_changed, 1'b0);
    chk("rst_seg_err", seg_err, 1'b0);
    chk("rst_stale", stale, 1'b1);
    rst = 1'b1;
    @(negedge clk);

    // first frame
    v0 = vcnt; c0 = ccnt;
    scan(seg[9], seg[9], seg[9], seg[9]);
    chk("f1_value", value, 16'h9999);
    chk("f1_valid_cnt", vcnt - v0, 1);
    chk("f1_changed_cnt", ccnt - c0, 1);
    chk("f1_stale", stale, 1'b0);
    chk("f1_seg_err", seg_err, 1'b0);

    // identical frame, then one digit different
    v0 = vcnt; c0 = ccnt;
    scan(seg[9], seg[9], seg[9], seg[9]);
    chk("same_valid_cnt", vcnt - v0, 1);
    chk("same_changed_cnt", ccnt - c0, 0);
    v0 = vcnt; c0 = ccnt;
    scan(seg[9], seg[9], seg[8], seg[9]);
    chk("diff_value", value, 16'h9989);
    chk("diff_changed_cnt", ccnt - c0, 1);

    // too-short holds and illegal anodes never accept
    v0 = vcnt; c0 = ccnt;
    hold(4'b1110, seg[1], 3); hold(4'b1101, seg[2], 3);
    hold(4'b1011, seg[3], 3); hold(4'b0111, seg[4], 3);
    hold(4'b1110, seg[1], 3); hold(4'b1111, seg[0], 3);
    hold(4'b1101, seg[2], 3); hold(4'b1100, seg[0], 20);
    hold(4'b1011, seg[3], 3); hold(4'b1111, 8'hFF, 3);
    hold(4'b0111, seg[4], 3); hold(4'b1111, 8'hFF, 6);
    chk("short_value", value, 16'h9989);
    chk("short_valid_cnt", vcnt - v0, 0);
    chk("short_changed_cnt", ccnt - c0, 0);

    // long hold accepted once; frame completes exactly once
    v0 = vcnt; c0 = ccnt;
    hold(4'b1110, seg[1], 40);
    hold(4'b1101, seg[2], 6);
    hold(4'b1011, seg[3], 6);
    hold(4'b0111, seg[4], 6);
    hold(4'b1111, 8'hFF, 4);
    chk("long_value", value, 16'h4321);
    chk("long_valid_cnt", vcnt - v0, 1);
    chk("long_changed_cnt", ccnt - c0, 1);

    // blank and undecodable patterns
    scan(seg[7], 8'hFF, seg[5], 8'b1010_1010);
    chk("err_value", value, 16'h7F5E);
    chk("err_seg_err", seg_err, 1'b1);
    scan(seg[1], seg[2], seg[3], seg[4]);
    chk("sticky_value", value, 16'h1234);
    chk("sticky_seg_err", seg_err, 1'b1);

    // timeout drops the partial frame
    hold(4'b1110, seg[5], 6);
    hold(4'b1101, seg[6], 6);
    hold(4'b1111, 8'hFF, 70);
    chk("to_stale", stale, 1'b1);
    chk("to_value", value, 16'h1234);
    v0 = vcnt;
    hold(4'b1011, seg[7], 6);
    hold(4'b0111, seg[8], 6);
    hold(4'b1111, 8'hFF, 8);
    chk("to_partial_valid_cnt", vcnt - v0, 0);
    chk("to_partial_value", value, 16'h1234);
    chk("to_partial_stale", stale, 1'b1);
    scan(seg[8], seg[7], seg[6], seg[5]);
    chk("to_recover_value", value, 16'h8765);
    chk("to_recover_stale", stale, 1'b0);

    // reset mid-frame
    hold(4'b1110, seg[5], 6);
    hold(4'b1101, seg[6], 6);
    hold(4'b1011, seg[7], 6);
    rst = 1'b0;
    hold(4'b1111, 8'hFF, 2);
    chk("mid_rst_value", value, 16'h0000);
    chk("mid_rst_seg_err", seg_err, 1'b0);
    chk("mid_rst_stale", stale, 1'b1);
    chk("mid_rst_valid", value_valid, 1'b0);
    rst = 1'b1;
    hold(4'b0111, seg[8], 6);
    hold(4'b1111, 8'hFF, 4);
    chk("mid_rst_no_frame", value, 16'h0000);
    v0 = vcnt; c0 = ccnt;
    scan(seg[8], seg[7], seg[6], seg[5]);
    chk("post_rst_value", value, 16'h8765);
    chk("post_rst_valid_cnt", vcnt - v0, 1);
    chk("post_rst_changed_cnt", ccnt - c0, 1);
    chk("post_rst_stale", stale, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
